// File: rtl/reset_sequencer_if.sv
// rtl/reset_sequencer_if.sv - restart/ready inputs and reset/status outputs of reset_sequencer
interface reset_sequencer_if #(
  parameter int N_DOMAINS = 4
);
  logic                 restart;
  logic [N_DOMAINS-1:0] ready;
  logic [N_DOMAINS-1:0] resets;
  logic [3:0]           step;
  logic                 done;
  logic                 timeout;

  modport master (
    input  restart,
    input  ready,
    output resets,
    output step,
    output done,
    output timeout
  );

  modport slave (
    output restart,
    output ready,
    input  resets,
    input  step,
    input  done,
    input  timeout
  );
endinterface

// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - ordered LSB-first reset release with gap and ready wait; RST_SEQ_TIMEOUT_EN adds ready timeout/ERR
module reset_sequencer #(
  parameter int          N_DOMAINS     = 4,
  parameter logic [7:0]  HOLD_CYCLES   = 8'd16,
  parameter logic [31:0] STEP_DELAY    = 32'd100,
  parameter logic [31:0] READY_TIMEOUT = 32'd10000
) (
  input logic               i_clk,
  input logic               i_reset,
  reset_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_HOLD,
    S_DELAY,
    S_WAIT,
    S_DONE
`ifdef RST_SEQ_TIMEOUT_EN
    , S_ERR
`endif
  } state_t;

  localparam logic [3:0] LAST_STEP = 4'(N_DOMAINS - 1);

  state_t               state_q, state_n;
  logic [31:0]          cnt_q, cnt_n;
  logic [N_DOMAINS-1:0] resets_q, resets_n;
  logic [3:0]           step_q, step_n;
  logic                 done_q, done_n;
  logic                 ready_sel;
`ifdef RST_SEQ_TIMEOUT_EN
  logic                 timeout_q, timeout_n;
`endif

  // Next-state, counter and output decode; restart overrides everything else
  always_comb begin
    state_n   = state_q;
    cnt_n     = (cnt_q != 32'd0) ? cnt_q - 32'd1 : 32'd0;
    resets_n  = resets_q;
    step_n    = step_q;
    done_n    = done_q;
    ready_sel = 1'b0;
`ifdef RST_SEQ_TIMEOUT_EN
    timeout_n = timeout_q;
`endif
    for (int k = 0; k < N_DOMAINS; k++) begin
      if (step_q == 4'(k)) ready_sel = bus.ready[k];
    end

    case (state_q)
      S_HOLD: begin
        if (cnt_q == 32'd0) begin
          state_n = S_DELAY;
          cnt_n   = STEP_DELAY;
        end
      end
      S_DELAY: begin
        if (cnt_q == 32'd0) begin
          for (int k = 0; k < N_DOMAINS; k++) begin
            if (step_q == 4'(k)) resets_n[k] = 1'b0;
          end
          state_n = S_WAIT;
          cnt_n   = READY_TIMEOUT;
        end
      end
      S_WAIT: begin
        if (ready_sel) begin
          if (step_q == LAST_STEP) begin
            state_n = S_DONE;
            done_n  = 1'b1;
          end else begin
            step_n  = step_q + 4'd1;
            state_n = S_DELAY;
            cnt_n   = STEP_DELAY;
          end
        end
`ifdef RST_SEQ_TIMEOUT_EN
        else if (cnt_q == 32'd0) begin
          state_n   = S_ERR;
          resets_n  = '1;
          timeout_n = 1'b1;
          done_n    = 1'b0;
        end
`endif
      end
      S_DONE: begin
        state_n = S_DONE;
      end
`ifdef RST_SEQ_TIMEOUT_EN
      S_ERR: begin
        state_n = S_ERR;
      end
`endif
      default: begin
        state_n = S_HOLD;
        cnt_n   = {24'd0, HOLD_CYCLES};
      end
    endcase

    if (bus.restart) begin
      state_n   = S_HOLD;
      cnt_n     = {24'd0, HOLD_CYCLES};
      resets_n  = '1;
      step_n    = 4'd0;
      done_n    = 1'b0;
`ifdef RST_SEQ_TIMEOUT_EN
      timeout_n = 1'b0;
`endif
    end
  end

  // State and registered outputs; board reset dominates restart
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= S_HOLD;
      cnt_q     <= {24'd0, HOLD_CYCLES};
      resets_q  <= '1;
      step_q    <= 4'd0;
      done_q    <= 1'b0;
`ifdef RST_SEQ_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_n;
      cnt_q     <= cnt_n;
      resets_q  <= resets_n;
      step_q    <= step_n;
      done_q    <= done_n;
`ifdef RST_SEQ_TIMEOUT_EN
      timeout_q <= timeout_n;
`endif
    end
  end

  assign bus.resets  = resets_q;
  assign bus.step    = step_q;
  assign bus.done    = done_q;
`ifdef RST_SEQ_TIMEOUT_EN
  assign bus.timeout = timeout_q;
`else
  assign bus.timeout = 1'b0;
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// tb/tb_reset_sequencer.sv - scoreboard bench for reset_sequencer (both RST_SEQ_TIMEOUT_EN builds)
module tb_reset_sequencer;
  localparam int N    = 4;
  localparam int HOLD = 4;
  localparam int STEP = 3;
  localparam int TMO  = 20;

  typedef struct {
    int         cyc;
    logic [9:0] snap;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   cyc      = 0;
  int   checks   = 0;
  int   failures = 0;
  exp_t exp_q[$];
  logic [9:0] prev = 'x;

  reset_sequencer_if #(.N_DOMAINS(N)) bus ();

  reset_sequencer #(
    .N_DOMAINS    (N),
    .HOLD_CYCLES  (8'(HOLD)),
    .STEP_DELAY   (32'(STEP)),
    .READY_TIMEOUT(32'(TMO))
  ) dut (
    .i_clk  (clk),
    .i_reset(reset),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Edge counter: at the negedge following edge n, cyc == n
  always @(posedge clk) cyc <= cyc + 1;

  task automatic expect_at(input int c, input logic [3:0] r, input logic [3:0] s,
                           input logic d, input logic t);
    exp_t e;
    e.cyc  = c;
    e.snap = {r, s, d, t};
    exp_q.push_back(e);
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Monitor: every change of the output bundle must match the next expected change, at its edge
  always @(negedge clk) begin
    logic [9:0] cur;
    exp_t       e;
    cur = {bus.resets, bus.step, bus.done, bus.timeout};
    if (cur !== prev) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_change cyc=%0d got resets/step/done/timeout=%b", cyc, cur);
      end else begin
        e = exp_q.pop_front();
        if (e.cyc != cyc || e.snap !== cur) begin
          failures++;
          $display("FAIL output_change got cyc=%0d snap=%b want cyc=%0d snap=%b",
                   cyc, cur, e.cyc, e.snap);
        end
      end
      prev = cur;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d pending=%0d", cyc, exp_q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    int e;
    int f;
    logic [3:0] rm;
    logic [3:0] rm2;
    bus.restart = 1'b0;
    bus.ready   = '0;

    // Reset state, then release of domain 0
    expect_at(1, 4'b1111, 4'd0, 1'b0, 1'b0);
    wait_cyc(3);
    reset = 1'b0;
    r = 3;
    e = r + HOLD + STEP + 2;
    expect_at(e, 4'b1110, 4'd0, 1'b0, 1'b0);

    // Full sequence, each ready raised 2 cycles after its release
    for (int k = 0; k < N; k++) begin
      wait_cyc(e + 1);
      bus.ready[k] = 1'b1;
      f   = e + 2;
      rm  = 4'b1111 << (k + 1);
      rm2 = 4'b1111 << (k + 2);
      if (k < N - 1) begin
        expect_at(f, rm, 4'(k + 1), 1'b0, 1'b0);
        e = f + STEP + 1;
        expect_at(e, rm2, 4'(k + 1), 1'b0, 1'b0);
      end else begin
        expect_at(f, 4'b0000, 4'd3, 1'b1, 1'b0);
      end
    end

    // Reset and restart together during DONE behave as reset alone
    wait_cyc(f + 2);
    reset       = 1'b1;
    bus.restart = 1'b1;
    bus.ready   = '0;
    r = f + 3;
    expect_at(r, 4'b1111, 4'd0, 1'b0, 1'b0);
    wait_cyc(r);
    reset       = 1'b0;
    bus.restart = 1'b0;
    e = r + HOLD + STEP + 2;
    expect_at(e, 4'b1110, 4'd0, 1'b0, 1'b0);

    // Restart while step 2 is being delayed; ready[1] already high on WAIT entry
    wait_cyc(e + 1);
    bus.ready = 4'b0011;
    f = e + 2;
    expect_at(f, 4'b1110, 4'd1, 1'b0, 1'b0);
    expect_at(f + STEP + 1, 4'b1100, 4'd1, 1'b0, 1'b0);
    expect_at(f + STEP + 2, 4'b1100, 4'd2, 1'b0, 1'b0);
    wait_cyc(f + STEP + 3);
    bus.restart = 1'b1;
    bus.ready   = '0;
    expect_at(f + STEP + 4, 4'b1111, 4'd0, 1'b0, 1'b0);
    wait_cyc(f + STEP + 4);
    bus.restart = 1'b0;
    e = f + STEP + 4 + HOLD + STEP + 2;
    expect_at(e, 4'b1110, 4'd0, 1'b0, 1'b0);

    // Domain 1 never becomes ready
    wait_cyc(e + 1);
    bus.ready = 4'b0001;
    f = e + 2;
    expect_at(f, 4'b1110, 4'd1, 1'b0, 1'b0);
    e = f + STEP + 1;
    expect_at(e, 4'b1100, 4'd1, 1'b0, 1'b0);
`ifdef RST_SEQ_TIMEOUT_EN
    expect_at(e + TMO + 1, 4'b1111, 4'd1, 1'b0, 1'b1);
    wait_cyc(e + TMO + 3);
    bus.restart = 1'b1;
    bus.ready   = '0;
    expect_at(e + TMO + 4, 4'b1111, 4'd0, 1'b0, 1'b0);
    wait_cyc(e + TMO + 4);
    bus.restart = 1'b0;
    f = e + TMO + 4 + HOLD + STEP + 2;
    expect_at(f, 4'b1110, 4'd0, 1'b0, 1'b0);
    wait_cyc(f + 20);
`else
    wait_cyc(e + 1000);
    bus.ready = 4'b1111;
    f = e + 1001;
    expect_at(f,      4'b1100, 4'd2, 1'b0, 1'b0);
    expect_at(f + 4,  4'b1000, 4'd2, 1'b0, 1'b0);
    expect_at(f + 5,  4'b1000, 4'd3, 1'b0, 1'b0);
    expect_at(f + 9,  4'b0000, 4'd3, 1'b0, 1'b0);
    expect_at(f + 10, 4'b0000, 4'd3, 1'b1, 1'b0);
    wait_cyc(f + 30);
`endif

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL missing_changes got pending=%0d want pending=0 next_cyc=%0d",
               exp_q.size(), exp_q[0].cyc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
